// File: rtl/cpu_io_host.sv
// Host-side byte feeder and output recorder for the processor I/O port.
// Input FIFO drives data_in/Enter; dataOut changes go to a readback FIFO.
module cpu_io_host #(
  parameter int          DEPTH     = 8,
  parameter logic [3:0]  IN_STATE  = 4'd4,
  parameter logic [2:0]  IN_OPCODE = 3'b100,
  parameter int          GAP       = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       host_wr,
  input  logic [7:0] host_wdata,
  output logic       host_full,
  input  logic       host_rd,
  output logic [7:0] host_rdata,
  output logic       host_rvalid,
  output logic       ovf,
  output logic       starved,
  output logic [7:0] data_in,
  output logic       Enter,
  input  logic [7:0] dataOut,
  input  logic [3:0] CheckState,
  input  logic [2:0] IR,
  input  logic       Halt
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [GW-1:0] GAP_LD   = GW'(GAP - 1);

  typedef enum logic [1:0] {IDLE, PRESENT, GAPWAIT} state_t;

  state_t        st, st_n;
  logic [GW-1:0] cnt, cnt_n;
  logic [7:0]    din_n;
  logic          ent_n;
  logic          w;

  logic [7:0]    in_mem [DEPTH];
  logic [AW-1:0] in_wp, in_rp;
  logic [AW:0]   in_cnt;
  logic          in_empty, in_push, in_pop;

  logic [7:0]    out_mem [DEPTH];
  logic [AW-1:0] out_wp, out_rp;
  logic [AW:0]   out_cnt;
  logic          out_empty, out_full;
  logic          out_push, out_pop, cap;
  logic [7:0]    last_out;
  logic          halt_d;

  assign w = (CheckState == IN_STATE) && (IR == IN_OPCODE);

  assign in_empty  = (in_cnt == '0);
  assign host_full = (in_cnt == FULL_CNT);
  assign in_push   = host_wr && (!host_full || in_pop);

  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    din_n  = data_in;
    ent_n  = Enter;
    in_pop = 1'b0;
    case (st)
      IDLE: if (w && !in_empty) begin
        st_n   = PRESENT;
        din_n  = in_mem[in_rp];
        ent_n  = 1'b1;
        in_pop = 1'b1;
      end
      PRESENT: if (!w) begin
        st_n  = GAPWAIT;
        ent_n = 1'b0;
        cnt_n = GAP_LD;
      end
      GAPWAIT: begin
        if (cnt == '0) st_n = IDLE;
        else cnt_n = cnt - 1'b1;
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      st      <= IDLE;
      cnt     <= '0;
      data_in <= 8'h00;
      Enter   <= 1'b0;
      starved <= 1'b0;
    end else begin
      st      <= st_n;
      cnt     <= cnt_n;
      data_in <= din_n;
      Enter   <= ent_n;
      starved <= w && (st == IDLE) && in_empty;
    end
  end

  always_ff @(posedge Clock) begin
    if (in_push) in_mem[in_wp] <= host_wdata;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      in_wp  <= '0;
      in_rp  <= '0;
      in_cnt <= '0;
    end else begin
      if (in_push) in_wp <= in_wp + 1'b1;
      if (in_pop)  in_rp <= in_rp + 1'b1;
      if (in_push && !in_pop) in_cnt <= in_cnt + 1'b1;
      else if (!in_push && in_pop) in_cnt <= in_cnt - 1'b1;
    end
  end

  // Halt edge forces one capture even when dataOut is unchanged
  assign cap       = (dataOut != last_out) || (Halt && !halt_d);
  assign out_empty = (out_cnt == '0);
  assign out_full  = (out_cnt == FULL_CNT);
  assign out_pop   = host_rd && !out_empty;
  assign out_push  = cap && (!out_full || out_pop);

  assign host_rvalid = !out_empty;
  assign host_rdata  = out_empty ? 8'h00 : out_mem[out_rp];

  always_ff @(posedge Clock) begin
    if (out_push) out_mem[out_wp] <= dataOut;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      out_wp   <= '0;
      out_rp   <= '0;
      out_cnt  <= '0;
      last_out <= 8'h00;
      halt_d   <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      halt_d <= Halt;
      if (cap) last_out <= dataOut;
      if (cap && !out_push) ovf <= 1'b1;
      if (out_push) out_wp <= out_wp + 1'b1;
      if (out_pop)  out_rp <= out_rp + 1'b1;
      if (out_push && !out_pop) out_cnt <= out_cnt + 1'b1;
      else if (!out_push && out_pop) out_cnt <= out_cnt - 1'b1;
    end
  end

endmodule
